// File: rtl/inst_fetch_pkg.sv
// Shared types for the instruction fetch stage: FSM states and the
// decode-facing and memctrl-facing register bundles.
package inst_fetch_pkg;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_MISS = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic              valid;
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
  } id_out_t;

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
  } mc_req_t;

  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(4);
  endfunction

endpackage

// File: rtl/inst_fetch_icache.sv
// Direct-mapped instruction cache, one instruction per line.
// Combinational hit/read, single write port; only valid bits are reset.
module inst_fetch_icache
  import inst_fetch_pkg::*;
#(
  parameter int IDX_W = 8,
  parameter int TAG_W = ADDR_W - IDX_W - 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [TAG_W-1:0]  rd_tag,
  output logic              hit,
  output logic [INST_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [INST_W-1:0] wr_data
);

  localparam int LINES = 1 << IDX_W;

  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tag_ram  [LINES];
  logic [INST_W-1:0] data_ram [LINES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     valid <= '0;
    else if (wr_en) valid[wr_idx] <= 1'b1;
  end

  // Arrays carry no reset so they can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_ram[wr_idx]  <= wr_tag;
      data_ram[wr_idx] <= wr_data;
    end
  end

  assign hit     = valid[rd_idx] && (tag_ram[rd_idx] == rd_tag);
  assign rd_data = data_ram[rd_idx];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC, optional I-cache (IFETCH_ICACHE_EN), miss path to
// memctrl, and redirect handling that defers jumps arriving mid-miss.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int          ICACHE_IDX_W = 8,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        iJUMP_en,
  input  logic [31:0] iJUMP_pc,
  input  logic        iID_stall,
  output logic        oID_valid,
  output logic [31:0] oID_inst,
  output logic [31:0] oID_pc,
  output logic        oMC_en,
  output logic [31:0] oMC_addr,
  input  logic        iMC_done,
  input  logic [31:0] iMC_inst
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  id_out_t           out_q, out_d;
  mc_req_t           mc_q, mc_d;
  logic              jpend_q, jpend_d;
  logic [ADDR_W-1:0] jpc_q, jpc_d;
  logic              adv, fill, hit;
  logic [INST_W-1:0] rdata;

`ifdef IFETCH_ICACHE_EN
  localparam int TAG_W = ADDR_W - ICACHE_IDX_W - 2;

  inst_fetch_icache #(.IDX_W(ICACHE_IDX_W), .TAG_W(TAG_W)) u_icache (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_idx  (pc_q[ICACHE_IDX_W+1:2]),
    .rd_tag  (pc_q[ADDR_W-1:ICACHE_IDX_W+2]),
    .hit     (hit),
    .rd_data (rdata),
    .wr_en   (fill & rdy),
    .wr_idx  (mc_q.addr[ICACHE_IDX_W+1:2]),
    .wr_tag  (mc_q.addr[ADDR_W-1:ICACHE_IDX_W+2]),
    .wr_data (iMC_inst)
  );
`else
  assign hit   = 1'b0;
  assign rdata = '0;
`endif

  assign adv = !out_q.valid || !iID_stall;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    out_d   = out_q;
    mc_d    = mc_q;
    jpend_d = jpend_q;
    jpc_d   = jpc_q;
    fill    = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if (iJUMP_en) begin
          pc_d        = iJUMP_pc;
          out_d.valid = 1'b0;
        end else if (adv) begin
          if (hit) begin
            out_d = '{valid: 1'b1, inst: rdata, pc: pc_q};
            pc_d  = pc_inc(pc_q);
          end else begin
            out_d.valid = 1'b0;
            state_d     = S_MISS;
            mc_d        = '{en: 1'b1, addr: pc_q};
          end
        end
      end
      S_MISS: begin
        if (iMC_done) begin
          fill    = 1'b1;
          mc_d.en = 1'b0;
          state_d = S_RUN;
          jpend_d = 1'b0;
          // Fill still happens on a redirected miss; only the emit is dropped.
          if (jpend_q || iJUMP_en) begin
            pc_d = iJUMP_en ? iJUMP_pc : jpc_q;
          end else begin
            out_d = '{valid: 1'b1, inst: iMC_inst, pc: mc_q.addr};
            pc_d  = pc_inc(mc_q.addr);
          end
        end else if (iJUMP_en) begin
          jpend_d = 1'b1;
          jpc_d   = iJUMP_pc;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      pc_q    <= RESET_PC;
      out_q   <= '0;
      mc_q    <= '0;
      jpend_q <= 1'b0;
      jpc_q   <= '0;
    end else if (rdy) begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      mc_q    <= mc_d;
      jpend_q <= jpend_d;
      jpc_q   <= jpc_d;
    end
  end

  assign oID_valid = out_q.valid;
  assign oID_inst  = out_q.inst;
  assign oID_pc    = out_q.pc;
  assign oMC_en    = mc_q.en;
  assign oMC_addr  = mc_q.addr;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a fixed-latency memctrl model that
// returns addr ^ 32'hA5A5_0000; expectations switch on IFETCH_ICACHE_EN.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst_n, rdy, jen, stall, mc_done, mc_en, id_valid;
  logic [31:0] jpc, mc_inst, mc_addr, id_inst, id_pc;

  always #5 clk = ~clk;

  inst_fetch #(.ICACHE_IDX_W(8), .RESET_PC(32'h0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rdy       (rdy),
    .iJUMP_en  (jen),
    .iJUMP_pc  (jpc),
    .iID_stall (stall),
    .oID_valid (id_valid),
    .oID_inst  (id_inst),
    .oID_pc    (id_pc),
    .oMC_en    (mc_en),
    .oMC_addr  (mc_addr),
    .iMC_done  (mc_done),
    .iMC_inst  (mc_inst)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [31:0] req_q[$], acc_pc[$], acc_inst[$];
  int          acc_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] req_at(input int i);
    return (i < req_q.size()) ? req_q[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] pc_at(input int i);
    return (i < acc_pc.size()) ? acc_pc[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] inst_at(input int i);
    return (i < acc_inst.size()) ? acc_inst[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic int count_req(input logic [31:0] a);
    int n = 0;
    foreach (req_q[i]) if (req_q[i] == a) n++;
    return n;
  endfunction

  function automatic logic [31:0] req_after(input logic [31:0] a);
    for (int i = 0; i + 1 < req_q.size(); i++)
      if (req_q[i] == a) return req_q[i+1];
    return 32'hDEAD_BEEF;
  endfunction

  // memctrl model + accept/request monitor, all decisions on negedge
  initial begin
    int          cnt;
    bit          busy;
    logic [31:0] a;
    cnt = 0; busy = 1'b0; a = '0;
    mc_done = 1'b0; mc_inst = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 1'b0; mc_done = 1'b0;
      end else begin
        if (rdy && id_valid && !stall) begin
          acc_pc.push_back(id_pc);
          acc_inst.push_back(id_inst);
          acc_cyc.push_back(cyc);
        end
        if (mc_done) begin
          mc_done = 1'b0; busy = 1'b0;
        end else if (!busy && mc_en) begin
          busy = 1'b1; cnt = 0; a = mc_addr; req_q.push_back(a);
        end else if (busy && rdy) begin
          cnt++;
          if (cnt >= 5) begin mc_done = 1'b1; mc_inst = inst_of(a); end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic jump(input logic [31:0] a);
    jpc = a; jen = 1'b1; step(1); jen = 1'b0;
  endtask

  task automatic wait_acc(input int n);
    int b = 0;
    while (acc_pc.size() < n && b < 300) begin step(1); b++; end
    chk($sformatf("wait_acc_%0d", n), 32'(acc_pc.size() >= n), 32'd1);
  endtask

  task automatic wait_mc(input logic any, input logic [31:0] a);
    int b = 0;
    while (!(mc_en && (any || mc_addr == a)) && b < 300) begin step(1); b++; end
    chk("wait_mc", 32'(mc_en), 32'd1);
  endtask

  task automatic wait_valid();
    int b = 0;
    while (!id_valid && b < 300) begin step(1); b++; end
    chk("wait_valid", 32'(id_valid), 32'd1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(id_valid), 32'd0);
    chk({tag, "_inst"},  id_inst, 32'd0);
    chk({tag, "_pc"},    id_pc,   32'd0);
    chk({tag, "_mc_en"}, 32'(mc_en), 32'd0);
    chk({tag, "_mc_addr"}, mc_addr, 32'd0);
  endtask

  initial begin
    int nr, na;
    rst_n = 1'b1; rdy = 1'b1; jen = 1'b0; jpc = '0; stall = 1'b0;
    #3 rst_n = 1'b0;
    step(3);
    chk_zero("rst");
    rst_n = 1'b1;

    // cold start
    wait_acc(3);
    chk("cold_req0", req_at(0), 32'h0);
    chk("cold_req1", req_at(1), 32'h4);
    chk("cold_req2", req_at(2), 32'h8);
    chk("cold_pc0",  pc_at(0),  32'h0);
    chk("cold_pc1",  pc_at(1),  32'h4);
    chk("cold_pc2",  pc_at(2),  32'h8);
    chk("cold_inst0", inst_at(0), 32'hA5A5_0000);
    chk("cold_inst2", inst_at(2), 32'hA5A5_0008);

    // loop back to 0 while the miss at 12 is outstanding
    jump(32'h0);
    wait_acc(7);
    chk("loop_pc3", pc_at(3), 32'h0);
    chk("loop_pc4", pc_at(4), 32'h4);
    chk("loop_pc5", pc_at(5), 32'h8);
    chk("loop_pc6", pc_at(6), 32'hC);
    chk("loop_inst6", inst_at(6), 32'hA5A5_000C);
`ifdef IFETCH_ICACHE_EN
    chk("loop_b2b", 32'(acc_cyc[6] - acc_cyc[3]), 32'd3);
    chk("loop_req0_once", 32'(count_req(32'h0)), 32'd1);
`else
    chk("loop_req0_twice", 32'(count_req(32'h0)), 32'd2);
`endif

    // decode stall holds output and pc
    stall = 1'b1;
    wait_valid();
    step(4);
    chk("stall_valid", 32'(id_valid), 32'd1);
    chk("stall_pc",    id_pc,   32'h10);
    chk("stall_inst",  id_inst, 32'hA5A5_0010);
    chk("stall_mc_en", 32'(mc_en), 32'd0);
`ifdef IFETCH_ICACHE_EN
    chk("loop_req4", req_at(4), 32'h10);
`endif
    stall = 1'b0;
    wait_acc(9);
    chk("stall_rel_pc7", pc_at(7), 32'h10);
    chk("stall_rel_pc8", pc_at(8), 32'h14);

    // redirect two cycles into the miss at 0x40
    jump(32'h40);
    wait_mc(1'b0, 32'h40);
    step(2);
    jump(32'h100);
    wait_acc(10);
    chk("jmiss_pc9", pc_at(9), 32'h100);
    chk("jmiss_next_req", req_after(32'h40), 32'h100);
    jump(32'h40);
    wait_acc(11);
    chk("refetch_pc", pc_at(10), 32'h40);
    chk("refetch_inst", inst_at(10), 32'hA5A5_0040);
`ifdef IFETCH_ICACHE_EN
    chk("refetch_hit", 32'(count_req(32'h40)), 32'd1);
`else
    chk("refetch_req", 32'(count_req(32'h40)), 32'd2);
`endif

    // aliasing: 0x400 evicts line 0
    jump(32'h400);
    wait_acc(12);
    chk("alias_pc", pc_at(11), 32'h400);
    chk("alias_inst", inst_at(11), 32'hA5A5_0400);
    jump(32'h0);
    wait_acc(13);
    chk("alias_back_pc", pc_at(12), 32'h0);
    chk("alias_back_req", req_after(32'h404), 32'h0);

    // pc wrap
    jump(32'hFFFF_FFFC);
    wait_acc(15);
    chk("wrap_pc_hi", pc_at(13), 32'hFFFF_FFFC);
    chk("wrap_inst_hi", inst_at(13), 32'h5A5A_FFFC);
    chk("wrap_pc_0", pc_at(14), 32'h0);

    // rdy low for 3 cycles mid-miss (miss at 4)
    wait_mc(1'b1, 32'h0);
    step(1);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("frz_mc_en",   32'(mc_en), 32'd1);
      chk("frz_mc_addr", mc_addr, 32'h4);
      chk("frz_valid",   32'(id_valid), 32'd0);
    end
    rdy = 1'b1;
    wait_acc(16);
    chk("frz_pc", pc_at(15), 32'h4);
    chk("frz_inst", inst_at(15), 32'hA5A5_0004);

    // async reset mid-miss
    wait_mc(1'b1, 32'h0);
    step(2);
    rst_n = 1'b0;
    #1 chk_zero("arst");
    step(1);
    rst_n = 1'b1;
    nr = req_q.size();
    na = acc_pc.size();
    wait_acc(na + 2);
    chk("arst_req0", req_at(nr),     32'h0);
    chk("arst_req1", req_at(nr + 1), 32'h4);
    chk("arst_pc0",  pc_at(na),      32'h0);
    chk("arst_pc1",  pc_at(na + 1),  32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
